// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into PULSE_LEN-cycle pulses separated by at least GAP_LEN low cycles.
// Requests that arrive during a pulse wait in a saturating counter; a request dropped while the counter is full sets a sticky overflow flag.
module pulse_stretcher #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 2,
    parameter int PEND_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulseIn,
    input  logic              clrOvf,
    output logic              pulseOut,
    output logic              busy,
    output logic [PEND_W-1:0] pendCnt,
    output logic              ovf
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int TW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [TW-1:0]     PULSE_LOAD = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0]     GAP_LOAD   = TW'(GAP_LEN - 1);
    localparam logic [TW-1:0]     TIMER_ZERO = TW'(0);
    localparam logic [TW-1:0]     TIMER_ONE  = TW'(1);
    localparam logic [PEND_W-1:0] PEND_ZERO  = PEND_W'(0);
    localparam logic [PEND_W-1:0] PEND_ONE   = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX   = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [PEND_W-1:0] pend_q,  pend_d;
    logic              ovf_q,   ovf_d;
    logic              pulse_out_q;
    logic              busy_q;
    logic              req_s;
    logic              start_s;
    logic              drop_s;

    // Next state, timer, pending counter and overflow flag.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        start_s = 1'b0;
        drop_s  = 1'b0;
        req_s   = pulseIn | (pend_q != PEND_ZERO);

        case (state_q)
            IDLE: begin
                if (req_s) begin
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HIGH: begin
                if (timer_q != TIMER_ZERO) begin
                    timer_d = timer_q - TIMER_ONE;
                end else begin
                    state_d = GAP;
                    timer_d = GAP_LOAD;
                end
            end
            GAP: begin
                if (timer_q != TIMER_ZERO) begin
                    timer_d = timer_q - TIMER_ONE;
                end else if (req_s) begin
                    start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = TIMER_ZERO;
            end
        endcase

        if (start_s) begin
            state_d = HIGH;
            timer_d = PULSE_LOAD;
        end else begin
            timer_d = timer_d;
        end

        // A start consumes one request; a coincident strobe replaces a queued one.
        if (start_s) begin
            if ((pend_q != PEND_ZERO) && !pulseIn) begin
                pend_d = pend_q - PEND_ONE;
            end else begin
                pend_d = pend_q;
            end
        end else if (pulseIn) begin
            if (pend_q != PEND_MAX) begin
                pend_d = pend_q + PEND_ONE;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            pend_d = pend_q;
        end

        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clrOvf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers; outputs are decoded from the next state so they come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= TIMER_ZERO;
            pend_q      <= PEND_ZERO;
            ovf_q       <= 1'b0;
            pulse_out_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            pulse_out_q <= (state_d == HIGH);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign pulseOut = pulse_out_q;
    assign busy     = busy_q;
    assign pendCnt  = pend_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomised scoreboard bench: a time-since-start reference model predicts every output cycle.
module tb_pulse_stretcher;

    localparam int P    = 4;
    localparam int G    = 2;
    localparam int PW   = 2;
    localparam int MAXP = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pulseIn;
    logic          clrOvf;
    logic          pulseOut;
    logic          busy;
    logic [PW-1:0] pendCnt;
    logic          ovf;

    pulse_stretcher #(.PULSE_LEN(P), .GAP_LEN(G), .PEND_W(PW)) dut (
        .clk     (clk),
        .rst     (rst),
        .pulseIn (pulseIn),
        .clrOvf  (clrOvf),
        .pulseOut(pulseOut),
        .busy    (busy),
        .pendCnt (pendCnt),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    logic [4:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model: age = cycles since the last accepted start, idle when no pulse period is running
    bit m_idle = 1'b1;
    int m_age  = 0;
    int m_pend = 0;
    bit m_ovf  = 1'b0;

    task automatic model_step(input bit in, input bit clr, input bit r);
        bit can_start;
        bit start;
        bit setov;
        logic [4:0] e;
        setov = 1'b0;
        if (r) begin
            m_idle = 1'b1; m_age = 0; m_pend = 0; m_ovf = 1'b0;
        end else begin
            can_start = m_idle || (m_age == P + G - 1);
            start     = can_start && (in || m_pend > 0);
            if (start) begin
                if (m_pend > 0) m_pend = m_pend - 1 + (in ? 1 : 0);
                m_idle = 1'b0;
                m_age  = 0;
            end else begin
                if (!m_idle) begin
                    m_age++;
                    if (m_age == P + G) m_idle = 1'b1;
                end
                if (in) begin
                    if (m_pend < MAXP) m_pend++;
                    else setov = 1'b1;
                end
            end
            if (setov) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        e[4]   = !m_idle && (m_age < P);
        e[3]   = !m_idle;
        e[2:1] = m_pend[1:0];
        e[0]   = m_ovf;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit in, input bit clr, input bit r);
        @(negedge clk);
        pulseIn = in;
        clrOvf  = clr;
        rst     = r;
        model_step(in, clr, r);
    endtask

    // monitor: every cycle the DUT presents a new output word after the rising edge
    initial begin
        logic [4:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({pulseOut, busy, pendCnt, ovf} !== e) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got pulseOut=%b busy=%b pendCnt=%0d ovf=%b exp pulseOut=%b busy=%b pendCnt=%0d ovf=%b",
                             cyc, pulseOut, busy, pendCnt, ovf, e[4], e[3], e[2:1], e[0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dens;
        pulseIn = 1'b0;
        clrOvf  = 1'b0;
        rst     = 1'b1;
        drive(0, 0, 1);
        drive(0, 0, 1);
        repeat (3) drive(0, 0, 0);
        // single strobe
        drive(1, 0, 0);
        repeat (10) drive(0, 0, 0);
        // three consecutive strobes, then six to overflow the queue
        repeat (3) drive(1, 0, 0);
        repeat (20) drive(0, 0, 0);
        repeat (6) drive(1, 0, 0);
        repeat (30) drive(0, 0, 0);
        // clear racing a drop keeps ovf set; a lone clear then clears it
        drive(0, 1, 0);
        repeat (4) drive(1, 0, 0);
        drive(1, 1, 0);
        drive(0, 1, 0);
        repeat (30) drive(0, 0, 0);
        // queued request plus a strobe in the last gap cycle
        repeat (2) drive(1, 0, 0);
        repeat (4) drive(0, 0, 0);
        drive(1, 0, 0);
        repeat (20) drive(0, 0, 0);
        // reset in the middle of a high phase with a full-ish queue and ovf set
        repeat (6) drive(1, 0, 0);
        drive(0, 0, 1);
        repeat (15) drive(0, 0, 0);
        // randomised phases of varying strobe density
        for (int blk = 0; blk < 15; blk++) begin
            dens = $urandom_range(0, 100);
            for (int i = 0; i < 200; i++) begin
                drive($urandom_range(0, 99) < dens, $urandom_range(0, 39) == 0,
                      $urandom_range(0, 299) == 0);
            end
        end
        repeat (30) drive(0, 0, 0);
        @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d unchecked entries, exp 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
